// File: rtl/booth_mult8_pkg.sv
// Shared types for the Booth multiplier issue stage.
// Holds the width default, the sign-mode encoding and the issue FSM state encoding.
package booth_mult8_pkg;

    localparam int WIDTH_DEF = 8;

    // Bit 1: A is signed, bit 0: B is signed.
    typedef enum logic [1:0] {
        UU = 2'b00,
        US = 2'b01,
        SU = 2'b10,
        SS = 2'b11
    } sign_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/booth_issue_fifo.sv
// Operand request FIFO feeding the multiplier issue FSM.
// Ports: clk, rst_n, push/push_data, pop, flush, head_data, empty, full.
module booth_issue_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush beats a simultaneous push.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/booth_mult8_issue.sv
// Issue stage: queues operand requests and feeds them one at a time to the
// multiplier core, holding each product until the consumer takes it.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_sign_mode request side;
// flush; core_start/core_a/core_b/core_sign_mode, core_product/core_done to
// the core; res_valid/res_ready/res_product result side; busy.
// Optional macro BOOTH_ISSUE_TAG_EN adds in_tag and res_tag.
module booth_mult8_issue
    import booth_mult8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_sign_mode,
`ifdef BOOTH_ISSUE_TAG_EN
    input  logic [3:0]         in_tag,
`endif
    input  logic               flush,
    output logic               core_start,
    output logic [WIDTH-1:0]   core_a,
    output logic [WIDTH-1:0]   core_b,
    output logic [1:0]         core_sign_mode,
    input  logic [2*WIDTH-1:0] core_product,
    input  logic               core_done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
`ifdef BOOTH_ISSUE_TAG_EN
    output logic [3:0]         res_tag,
`endif
    output logic               busy
);

`ifdef BOOTH_ISSUE_TAG_EN
    localparam int TW = 4;
`else
    localparam int TW = 0;
`endif
    localparam int DW = 2*WIDTH + 2 + TW;

    state_t           state;
    state_t           state_nxt;
    logic             issue;
    logic             load;
    logic             empty;
    logic             full;
    logic [DW-1:0]    push_data;
    logic [DW-1:0]    head_data;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [1:0]       head_mode;

`ifdef BOOTH_ISSUE_TAG_EN
    logic [3:0] head_tag;
    logic [3:0] flight_tag;
    assign push_data = {in_tag, in_sign_mode, in_a, in_b};
    assign {head_tag, head_mode, head_a, head_b} = head_data;
`else
    assign push_data = {in_sign_mode, in_a, in_b};
    assign {head_mode, head_a, head_b} = head_data;
`endif

    assign in_ready = !full;

    booth_issue_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (push_data),
        .pop       (issue),
        .flush     (flush),
        .head_data (head_data),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Issue only when the result slot is free or being drained this cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !flush && (!res_valid || res_ready)) begin
                    issue     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (core_done) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        core_start     = issue;
        core_a         = issue ? head_a : '0;
        core_b         = issue ? head_b : '0;
        core_sign_mode = issue ? head_mode : 2'(UU);
    end

    // core_done outside BUSY is stale and dropped.
    assign load = (state == BUSY) && core_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_product <= '0;
        end else if (load) begin
            res_valid   <= 1'b1;
            res_product <= core_product;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

`ifdef BOOTH_ISSUE_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flight_tag <= '0;
            res_tag    <= '0;
        end else begin
            if (issue) flight_tag <= head_tag;
            if (load)  res_tag    <= flight_tag;
        end
    end
`endif

    assign busy = (state == BUSY) || res_valid;

endmodule

// File: tb/tb_booth_mult8_issue.sv
// Self-checking bench for booth_mult8_issue with a behavioural multiplier
// core model, vector table, corner sequences and a random scoreboard.
`timescale 1ns/1ps
module tb_booth_mult8_issue;
    import booth_mult8_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_sign_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        core_start;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic [1:0]  core_sign_mode;
    logic [15:0] core_product = '0;
    logic        core_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_product;
    logic [3:0]  res_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  m;
        logic [15:0] p;
    } vec_t;
    vec_t vt[9];

    booth_mult8_issue #(.WIDTH(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_sign_mode   (in_sign_mode),
`ifdef BOOTH_ISSUE_TAG_EN
        .in_tag         (in_tag),
`endif
        .flush          (flush),
        .core_start     (core_start),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_sign_mode (core_sign_mode),
        .core_product   (core_product),
        .core_done      (core_done),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_product    (res_product),
`ifdef BOOTH_ISSUE_TAG_EN
        .res_tag        (res_tag),
`endif
        .busy           (busy)
    );

`ifndef BOOTH_ISSUE_TAG_EN
    assign res_tag = '0;
`endif

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(logic [7:0] a, logic [7:0] b,
                                             logic [1:0] m);
        int ai;
        int bi;
        ai = m[1] ? int'($signed(a)) : int'(a);
        bi = m[0] ? int'($signed(b)) : int'(b);
        return 16'(ai * bi);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural core: fixed latency, ignores rst_n so stale pulses occur.
    int          core_cnt = 0;
    logic [15:0] core_pend = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done    <= 1'b1;
                core_product <= core_pend;
            end
        end else if (core_start) begin
            core_cnt  <= LAT;
            core_pend <= ref_prod(core_a, core_b, core_sign_mode);
        end
    end

    always @(posedge clk) begin
        if (core_start) start_cnt++;
    end

    // Mid-cycle protocol monitor, away from both edges.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            checks++;
            if (!core_start && (core_a != 0 || core_b != 0
                                || core_sign_mode != 0)) begin
                errors++;
                $display("FAIL idle_operands: a=%h b=%h m=%b expected 0",
                         core_a, core_b, core_sign_mode);
            end
            checks++;
            if (core_start && core_cnt != 0) begin
                errors++;
                $display("FAIL start_while_core_busy: got 1 expected 0");
            end
        end
    end

    task automatic push_req(input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] m, input logic [3:0] t);
        exp_t e;
        in_valid     = 1'b1;
        in_a         = a;
        in_b         = b;
        in_sign_mode = m;
        in_tag       = t;
        if (in_ready && !flush) begin
            e.p = ref_prod(a, b, m);
            e.t = t;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        int   got;
        exp_t e;
        got = 0;
        res_ready = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (res_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", res_product, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ordered_product", res_product, e.p);
`ifdef BOOTH_ISSUE_TAG_EN
                    chk("ordered_tag", res_tag, e.t);
`endif
                end
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("drain_count", got, n);
    endtask

    initial begin
        int s0;
        int n_acc;
        int cyc;
        logic bad;
        exp_t e;

        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n_acc;
        int cyc;
        logic bad;
        exp_t e;

        vt[0] = '{8'hFD, 8'h05, SS, 16'hFFF1};
        vt[1] = '{8'hFF, 8'hFF, UU, 16'hFE01};
        vt[2] = '{8'hFF, 8'hFF, SU, 16'hFF01};
        vt[3] = '{8'hFF, 8'hFF, US, 16'hFF01};
        vt[4] = '{8'hFF, 8'hFF, SS, 16'h0001};
        vt[5] = '{8'h80, 8'h80, SS, 16'h4000};
        vt[6] = '{8'h80, 8'h80, UU, 16'h4000};
        vt[7] = '{8'h7F, 8'h80, US, 16'hC080};
        vt[8] = '{8'h00, 8'h9C, SS, 16'h0000};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_product", res_product, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, one request at a time
        for (int i = 0; i < 9; i++) begin
            in_valid     = 1'b1;
            in_a         = vt[i].a;
            in_b         = vt[i].b;
            in_sign_mode = vt[i].m;
            @(negedge clk);
            in_valid = 1'b0;
            chk("issue_next_cycle", core_start, 1);
            for (int c = 0; c < 20 && !res_valid; c++) @(negedge clk);
            chk("vec_res_valid", res_valid, 1);
            chk("vec_product", res_product, vt[i].p);
            @(negedge clk);
            chk("vec_hold_valid", res_valid, 1);
            chk("vec_hold_product", res_product, vt[i].p);
            chk("vec_busy", busy, 1);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("vec_accepted", res_valid, 0);
            chk("vec_idle_busy", busy, 0);
        end

        // Back-to-back UU then SU, in order
        push_req(8'hFF, 8'hFF, UU, 4'h3);
        push_req(8'hFF, 8'hFF, SU, 4'hA);
        drain(2, 60);

        // Backpressure: five pushes, one issue, FIFO full
        s0 = start_cnt;
        for (int i = 0; i < 5; i++)
            push_req(8'(i + 3), 8'(i * 7 + 1), 2'(i), 4'(i));
        chk("full_in_ready", in_ready, 0);
        chk("five_accepted", exp_q.size(), 5);
        repeat (12) @(negedge clk);
        chk("single_start", start_cnt - s0, 1);
        chk("held_result", res_valid, 1);
        chk("still_full", in_ready, 0);
        drain(5, 200);

        // Flush with three queued and one in flight, plus a colliding push
        s0 = start_cnt;
        for (int i = 0; i < 4; i++)
            push_req(8'(i + 9), 8'hF0, SS, 4'(i + 8));
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        flush = 1'b1;
        push_req(8'h55, 8'h66, UU, 4'hF);
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_no_start", core_start, 0);
        drain(1, 40);
        repeat (10) @(negedge clk);
        chk("flush_one_start", start_cnt - s0, 1);
        chk("flush_no_result", res_valid, 0);
        chk("flush_busy", busy, 0);

        // Reset two cycles after core_start
        push_req(8'h12, 8'h34, UU, 4'h1);
        chk("pre_rst_start", core_start, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_product", res_product, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid || busy) bad = 1'b1;
        end
        chk("stale_done_ignored", bad, 0);

`ifdef BOOTH_ISSUE_TAG_EN
        push_req(8'h21, 8'h03, UU, 4'h3);
        push_req(8'hFE, 8'h09, SU, 4'hA);
        drain(2, 60);
`endif

        // Random traffic against the scoreboard
        n_acc = 0;
        cyc = 0;
        while ((n_acc < 40 || exp_q.size() != 0) && cyc < 3000) begin
            in_valid     = (n_acc < 40) && ($urandom_range(0, 2) != 0);
            in_a         = 8'($urandom);
            in_b         = 8'($urandom);
            in_sign_mode = 2'($urandom);
            in_tag       = 4'($urandom);
            res_ready    = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected", res_product, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_product", res_product, e.p);
`ifdef BOOTH_ISSUE_TAG_EN
                    chk("rand_tag", res_tag, e.t);
`endif
                end
            end
            if (in_valid && in_ready) begin
                e.p = ref_prod(in_a, in_b, in_sign_mode);
                e.t = in_tag;
                exp_q.push_back(e);
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        chk("rand_accepted", n_acc, 40);
        chk("rand_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
